alu_exc_unit: RTL and testbench

// Consumer side of the ALU status interface. Samples the 8-bit alu_status vector on each valid EX-stage op,

---
 rtl/alu_exc_unit_if.sv | 33 +++
 rtl/alu_exc_unit.sv | 103 ++++++++++
 tb/tb_alu_exc_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_exc_unit_if.sv
// ALU status / exception request bundle.
// slave = exception unit, master = ALU + pipeline control.
interface alu_exc_unit_if;
  logic        status_valid;
  logic [7:0]  alu_status;
  logic [31:0] pc_ex;
  logic        status_clr;
  logic        exc_ack;
  logic [7:0]  flags_q;
  logic [7:0]  sticky_flags;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] epc;
  logic        stall;
  logic        flush_ex;
  logic [7:0]  exc_count;

  modport slave (
    input  status_valid, alu_status, pc_ex,
    input  status_clr, exc_ack,
    output flags_q, sticky_flags, exc_req,
    output exc_code, epc, stall, flush_ex,
    output exc_count
  );

  modport master (
    output status_valid, alu_status, pc_ex,
    output status_clr, exc_ack,
    input  flags_q, sticky_flags, exc_req,
    input  exc_code, epc, stall, flush_ex,
    input  exc_count
  );
endinterface

// File: rtl/alu_exc_unit.sv
// ALU status consumer: flag capture, sticky flags and
// exception request FSM with EPC/cause capture.
module alu_exc_unit #(
  parameter logic [7:0] EXC_MASK   = 8'b0100_1100,
  parameter logic [4:0] CODE_DIV0  = 5'd13,
  parameter logic [4:0] CODE_OVF   = 5'd12,
  parameter logic [4:0] CODE_ALIGN = 5'd4
) (
  input logic           clk,
  input logic           rst_n,
  alu_exc_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state;
  state_t      nxt;
  logic        accept;
  logic        raise;
  logic [7:0]  masked;
  logic [4:0]  code_sel;
  logic [7:0]  flags_r;
  logic [7:0]  sticky_r;
  logic [4:0]  code_r;
  logic [31:0] epc_r;
  logic [7:0]  count_r;

  assign accept = (state == IDLE) && bus.status_valid;
  assign masked = bus.alu_status & EXC_MASK;
  assign raise  = accept && (|masked);

  always_comb begin
    code_sel = CODE_ALIGN;
    if (masked[2])      code_sel = CODE_DIV0;
    else if (masked[6]) code_sel = CODE_OVF;
    else                code_sel = CODE_ALIGN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (raise) nxt = REQ;
      REQ:     if (bus.exc_ack) nxt = FLUSH;
      FLUSH:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.exc_req  = 1'b0;
    bus.stall    = 1'b0;
    bus.flush_ex = 1'b0;
    unique case (state)
      REQ: begin
        bus.exc_req = 1'b1;
        bus.stall   = 1'b1;
      end
      FLUSH: begin
        bus.flush_ex = 1'b1;
        bus.stall    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r  <= '0;
      sticky_r <= '0;
      code_r   <= '0;
      epc_r    <= '0;
      count_r  <= '0;
    end else begin
      if (accept) flags_r <= bus.alu_status;
      // a clear coinciding with an accepted op keeps that op's flags
      if (bus.status_clr)
        sticky_r <= accept ? bus.alu_status : 8'h00;
      else if (accept)
        sticky_r <= sticky_r | bus.alu_status;
      if (raise) begin
        epc_r  <= bus.pc_ex;
        code_r <= code_sel;
        if (count_r != 8'hFF) count_r <= count_r + 8'd1;
      end
    end
  end

  assign bus.flags_q      = flags_r;
  assign bus.sticky_flags = sticky_r;
  assign bus.exc_code     = code_r;
  assign bus.epc          = epc_r;
  assign bus.exc_count    = count_r;

endmodule

// File: tb/tb_alu_exc_unit.sv
// Scoreboard bench for alu_exc_unit: directed ops push
// expected exceptions, a monitor checks each new request.
module tb_alu_exc_unit;

  typedef struct {
    logic [31:0] epc;
    logic [4:0]  code;
    logic [7:0]  count;
  } exp_t;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   tot_cnt;
  exp_t exp_q[$];
  logic req_d;

  alu_exc_unit_if ifc();

  alu_exc_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  initial req_d = 1'b0;
  always @(negedge clk) begin
    if (ifc.exc_req === 1'b1 && req_d !== 1'b1) begin
      if (exp_q.size() == 0) begin
        tot_cnt++;
        $display("FAIL sb_unexpected: got exc_req expected none");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_epc", ifc.epc, e.epc);
        chk("sb_code", {27'd0, ifc.exc_code}, {27'd0, e.code});
        chk("sb_count", {24'd0, ifc.exc_count}, {24'd0, e.count});
      end
    end
    req_d = ifc.exc_req;
  end

  task automatic expect_exc(input logic [31:0] pc,
                            input logic [4:0] code,
                            input logic [7:0] cnt);
    exp_t e;
    e.epc = pc;
    e.code = code;
    e.count = cnt;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [7:0] st,
                       input logic [31:0] pc);
    @(negedge clk);
    ifc.status_valid = 1'b1;
    ifc.alu_status   = st;
    ifc.pc_ex        = pc;
    @(negedge clk);
    ifc.status_valid = 1'b0;
  endtask

  task automatic ack_after(input int n);
    for (int i = 0; i < n; i++) begin
      chk("req_hold", {31'd0, ifc.exc_req}, 32'd1);
      chk("stall_req", {31'd0, ifc.stall}, 32'd1);
      if (i < n - 1) @(negedge clk);
    end
    ifc.exc_ack = 1'b1;
    @(negedge clk);
    ifc.exc_ack = 1'b0;
    chk("req_drop", {31'd0, ifc.exc_req}, 32'd0);
    chk("flush_on", {31'd0, ifc.flush_ex}, 32'd1);
    chk("stall_flush", {31'd0, ifc.stall}, 32'd1);
    @(negedge clk);
    chk("flush_off", {31'd0, ifc.flush_ex}, 32'd0);
    chk("stall_off", {31'd0, ifc.stall}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, {31'd0, ifc.exc_req}, 32'd0);
    chk({tag, "_stall"}, {31'd0, ifc.stall}, 32'd0);
    chk({tag, "_flush"}, {31'd0, ifc.flush_ex}, 32'd0);
    chk({tag, "_flags"}, {24'd0, ifc.flags_q}, 32'd0);
    chk({tag, "_sticky"}, {24'd0, ifc.sticky_flags}, 32'd0);
    chk({tag, "_code"}, {27'd0, ifc.exc_code}, 32'd0);
    chk({tag, "_epc"}, ifc.epc, 32'd0);
    chk({tag, "_count"}, {24'd0, ifc.exc_count}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ecnt;
    pass_cnt = 0;
    tot_cnt  = 0;
    rst_n = 1'b0;
    ifc.status_valid = 1'b0;
    ifc.alu_status   = 8'h00;
    ifc.pc_ex        = 32'h0;
    ifc.status_clr   = 1'b0;
    ifc.exc_ack      = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    rst_n = 1'b1;

    // reset while a request is pending
    expect_exc(32'h0000_1000, 5'd12, 8'd1);
    issue(8'h40, 32'h0000_1000);
    chk("t1_req", {31'd0, ifc.exc_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t1_async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_idle", {31'd0, ifc.exc_req}, 32'd0);

    // overflow, ack held off so request lasts three cycles
    expect_exc(32'h0040_0010, 5'd12, 8'd1);
    issue(8'h40, 32'h0040_0010);
    ack_after(3);
    chk("t2_epc", ifc.epc, 32'h0040_0010);
    chk("t2_count", {24'd0, ifc.exc_count}, 32'd1);

    // priority
    expect_exc(32'h0000_0200, 5'd13, 8'd2);
    issue(8'h44, 32'h0000_0200);
    ack_after(1);
    expect_exc(32'h0000_0300, 5'd12, 8'd3);
    issue(8'h48, 32'h0000_0300);
    ack_after(1);

    // non-exception flags
    @(negedge clk);
    ifc.status_clr = 1'b1;
    @(negedge clk);
    ifc.status_clr = 1'b0;
    chk("t4_clr", {24'd0, ifc.sticky_flags}, 32'd0);
    chk("t4_clr_flags", {24'd0, ifc.flags_q}, 32'h48);
    issue(8'hB0, 32'h0000_0400);
    chk("t4_noreq", {31'd0, ifc.exc_req}, 32'd0);
    chk("t4_flags", {24'd0, ifc.flags_q}, 32'hB0);
    chk("t4_sticky", {24'd0, ifc.sticky_flags}, 32'hB0);
    issue(8'h20, 32'h0000_0404);
    chk("t4_flags2", {24'd0, ifc.flags_q}, 32'h20);
    chk("t4_sticky2", {24'd0, ifc.sticky_flags}, 32'hB0);
    chk("t4_code", {27'd0, ifc.exc_code}, 32'd12);

    // ops ignored while in REQ; ack ignored in IDLE
    expect_exc(32'h0000_0500, 5'd12, 8'd4);
    issue(8'h40, 32'h0000_0500);
    ifc.status_valid = 1'b1;
    ifc.alu_status   = 8'h04;
    ifc.pc_ex        = 32'h0000_0100;
    @(negedge clk);
    ifc.status_valid = 1'b0;
    chk("t5_flags", {24'd0, ifc.flags_q}, 32'h40);
    chk("t5_epc", ifc.epc, 32'h0000_0500);
    chk("t5_code", {27'd0, ifc.exc_code}, 32'd12);
    ack_after(1);
    ifc.exc_ack = 1'b1;
    @(negedge clk);
    ifc.exc_ack = 1'b0;
    chk("t5_ack_idle", {31'd0, ifc.flush_ex}, 32'd0);
    chk("t5_ack_req", {31'd0, ifc.exc_req}, 32'd0);
    @(negedge clk);
    chk("t5_ack_stall", {31'd0, ifc.stall}, 32'd0);

    // clear and set on the same edge
    ifc.status_valid = 1'b1;
    ifc.alu_status   = 8'h80;
    ifc.pc_ex        = 32'h0000_0600;
    ifc.status_clr   = 1'b1;
    @(negedge clk);
    ifc.status_valid = 1'b0;
    ifc.status_clr   = 1'b0;
    chk("t6_sticky", {24'd0, ifc.sticky_flags}, 32'h80);
    chk("t6_flags", {24'd0, ifc.flags_q}, 32'h80);

    // saturation of the exception counter
    ecnt = 8'd4;
    for (int i = 0; i < 256; i++) begin
      if (ecnt != 8'hFF) ecnt = ecnt + 8'd1;
      expect_exc(32'h0001_0000 + 32'(i * 4), 5'd13, ecnt);
      issue(8'h04, 32'h0001_0000 + 32'(i * 4));
      ack_after(1);
    end
    chk("t6_sat", {24'd0, ifc.exc_count}, 32'hFF);
    chk("t6_epc", ifc.epc, 32'h0001_03FC);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
